// File: rtl/bcd_tick_counter_pkg.sv
// Shared types and seven-segment constants for the BCD tick counter.
// Segment patterns are ordered {g,f,e,d,c,b,a} and stored active-high.
package bcd_tick_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_tick_counter_seg7_decode.sv
// Combinational BCD-to-seven-segment decoder with selectable output polarity.
// Non-BCD codes show a blank display.
module seg7_decode
    import bcd_tick_counter_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  bcd_t       digit,
    output logic [6:0] seg
);

    logic [6:0] pattern_s;

    // Look up the active-high pattern, then apply the board polarity
    always_comb begin
        pattern_s = SEG_BLANK;
        case (digit)
            4'd0:    pattern_s = SEG_0;
            4'd1:    pattern_s = SEG_1;
            4'd2:    pattern_s = SEG_2;
            4'd3:    pattern_s = SEG_3;
            4'd4:    pattern_s = SEG_4;
            4'd5:    pattern_s = SEG_5;
            4'd6:    pattern_s = SEG_6;
            4'd7:    pattern_s = SEG_7;
            4'd8:    pattern_s = SEG_8;
            4'd9:    pattern_s = SEG_9;
            default: pattern_s = SEG_BLANK;
        endcase
        if (ACTIVE_LOW) begin
            seg = ~pattern_s;
        end else begin
            seg = pattern_s;
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Synchronises the divided tick level, detects its rising edges and counts
// them as a two-digit BCD value with registered seven-segment outputs.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int MAX_COUNT      = 99,
    parameter int SYNC_STAGES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       tick_seen,
    output logic       wrap
);

    localparam bcd_t       MAX_TENS  = bcd_t'(MAX_COUNT / 10);
    localparam bcd_t       MAX_ONES  = bcd_t'(MAX_COUNT % 10);
    localparam logic [6:0] HEX_RESET = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    bcd_t                   ones_q, ones_d, tens_q, tens_d;
    logic                   tick_seen_q, tick_seen_d;
    logic                   wrap_q, wrap_d;
    logic [6:0]             hex0_q, hex0_d, hex1_q, hex1_d;
    logic                   sync_val_s, sync_valid_s, rise_s;

    // The reset value of the synchroniser is not a real observation of tick_in,
    // so arming waits until a sampled value has reached the last stage.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], tick_in};
        fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sync_val_s   = sync_q[SYNC_STAGES-1];
        sync_valid_s = fill_q[SYNC_STAGES-1];
        prev_d       = sync_val_s;
        armed_d      = armed_q | (sync_valid_s & ~sync_val_s);
        rise_s       = armed_q & sync_val_s & ~prev_q;
        tick_seen_d  = rise_s;
    end

    // BCD count update: clear beats counting, terminal count wraps to 00
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (rise_s && enable) begin
            if ((tens_q == MAX_TENS) && (ones_q == MAX_ONES)) begin
                ones_d = 4'd0;
                tens_d = 4'd0;
                wrap_d = 1'b1;
            end else if (ones_q >= 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else begin
            ones_d = ones_q;
            tens_d = tens_q;
        end
    end

    seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_ones (
        .digit (ones_q),
        .seg   (hex0_d)
    );

    seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_tens (
        .digit (tens_q),
        .seg   (hex1_d)
    );

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            fill_q      <= '0;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            tick_seen_q <= 1'b0;
            wrap_q      <= 1'b0;
            hex0_q      <= HEX_RESET;
            hex1_q      <= HEX_RESET;
        end else begin
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            tick_seen_q <= tick_seen_d;
            wrap_q      <= wrap_d;
            hex0_q      <= hex0_d;
            hex1_q      <= hex1_d;
        end
    end

    assign ones      = ones_q;
    assign tens      = tens_q;
    assign hex0      = hex0_q;
    assign hex1      = hex1_q;
    assign tick_seen = tick_seen_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: two instances (terminal count 99 and 23) share
// stimulus; a scoreboard checks each tick_seen pulse, a row table checks phases.
module tb_bcd_tick_counter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick_in = 1'b1;
    logic enable = 1'b1;
    logic clear = 1'b0;

    logic [3:0] a_ones, a_tens, b_ones, b_tens;
    logic [6:0] a_hex0, a_hex1, b_hex0, b_hex1;
    logic       a_seen, b_seen, a_wrap, b_wrap;

    always #5 clk = ~clk;

    bcd_tick_counter #(.MAX_COUNT(99), .SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .enable(enable), .clear(clear),
        .ones(a_ones), .tens(a_tens), .hex0(a_hex0), .hex1(a_hex1),
        .tick_seen(a_seen), .wrap(a_wrap)
    );

    bcd_tick_counter #(.MAX_COUNT(23), .SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .enable(enable), .clear(clear),
        .ones(b_ones), .tens(b_tens), .hex0(b_hex0), .hex1(b_hex1),
        .tick_seen(b_seen), .wrap(b_wrap)
    );

    typedef struct {
        int a_cnt;
        bit a_wrap;
        int b_cnt;
        bit b_wrap;
    } exp_t;

    typedef struct {
        bit en;
        bit clr;
        int n;
        int a_exp;
        int b_exp;
        int a_wr;
        int b_wr;
    } row_t;

    exp_t sb_q[$];
    row_t rows[9];

    int  checks = 0;
    int  failures = 0;
    int  seen_cnt = 0;
    int  a_wrap_cnt = 0;
    int  b_wrap_cnt = 0;
    int  model_a = 0;
    int  model_b = 0;
    bit  model_armed = 1'b0;
    bit  hex_pend = 1'b0;
    int  pend_a = 0;
    int  pend_b = 0;

    function automatic logic [6:0] seg_lo(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int next_cnt(input int cnt, input int max, input bit en, output bit w);
        w = 1'b0;
        if (!en) return cnt;
        if (cnt == max) begin
            w = 1'b1;
            return 0;
        end
        return cnt + 1;
    endfunction

    task automatic push_exp();
        exp_t e;
        bit   wa, wb;
        e.a_cnt  = next_cnt(model_a, 99, enable, wa);
        e.b_cnt  = next_cnt(model_b, 23, enable, wb);
        e.a_wrap = wa;
        e.b_wrap = wb;
        model_a  = e.a_cnt;
        model_b  = e.b_cnt;
        sb_q.push_back(e);
    endtask

    task automatic do_tick();
        @(posedge clk);
        #1 tick_in = 1'b1;
        if (model_armed) push_exp();
        repeat (4) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_a = 0;
        model_b = 0;
    endtask

    task automatic run_row(input int i);
        int s0, wa0, wb0;
        if (rows[i].clr) do_clear();
        enable = rows[i].en;
        s0  = seen_cnt;
        wa0 = a_wrap_cnt;
        wb0 = b_wrap_cnt;
        for (int k = 0; k < rows[i].n; k++) do_tick();
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("row%0d_a_ones", i), a_ones, rows[i].a_exp % 10);
        chk($sformatf("row%0d_a_tens", i), a_tens, rows[i].a_exp / 10);
        chk($sformatf("row%0d_b_count", i), b_tens * 10 + b_ones, rows[i].b_exp);
        chk($sformatf("row%0d_seen", i), seen_cnt - s0, rows[i].n);
        chk($sformatf("row%0d_a_wraps", i), a_wrap_cnt - wa0, rows[i].a_wr);
        chk($sformatf("row%0d_b_wraps", i), b_wrap_cnt - wb0, rows[i].b_wr);
        enable = 1'b1;
    endtask

    // Scoreboard and per-cycle monitor, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hex_pend = 1'b0;
            end else begin
                if (hex_pend) begin
                    chk("hex0", a_hex0, seg_lo(pend_a % 10));
                    chk("hex1", a_hex1, seg_lo(pend_a / 10));
                    chk("b_hex0", b_hex0, seg_lo(pend_b % 10));
                    chk("b_hex1", b_hex1, seg_lo(pend_b / 10));
                    hex_pend = 1'b0;
                end
                if (a_wrap) a_wrap_cnt++;
                if (b_wrap) b_wrap_cnt++;
                chk("b_range", int'((b_tens * 10 + b_ones) <= 23 && b_ones <= 9), 1);
                chk("a_range", int'(a_ones <= 9 && a_tens <= 9), 1);
                chk("b_seen_match", b_seen, a_seen);
                if (a_seen) begin
                    seen_cnt++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_tick_seen", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("a_ones", a_ones, e.a_cnt % 10);
                        chk("a_tens", a_tens, e.a_cnt / 10);
                        chk("a_wrap", a_wrap, e.a_wrap);
                        chk("b_ones", b_ones, e.b_cnt % 10);
                        chk("b_tens", b_tens, e.b_cnt / 10);
                        chk("b_wrap", b_wrap, e.b_wrap);
                        pend_a   = e.a_cnt;
                        pend_b   = e.b_cnt;
                        hex_pend = 1'b1;
                    end
                end else begin
                    chk("wrap_without_tick", int'(a_wrap | b_wrap), 0);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   s0;
        rows[0] = '{1'b1, 1'b0, 5,  5,  5,  0, 0};
        rows[1] = '{1'b1, 1'b1, 7,  7,  7,  0, 0};
        rows[2] = '{1'b0, 1'b0, 3,  7,  7,  0, 0};
        rows[3] = '{1'b1, 1'b0, 2,  9,  9,  0, 0};
        rows[4] = '{1'b1, 1'b1, 24, 24, 0,  0, 1};
        rows[5] = '{1'b1, 1'b0, 75, 99, 3,  0, 3};
        rows[6] = '{1'b1, 1'b0, 1,  0,  4,  1, 0};
        rows[7] = '{1'b1, 1'b1, 42, 42, 18, 0, 1};
        rows[8] = '{1'b1, 1'b0, 57, 57, 9,  0, 2};

        // Reset state, released while tick_in is high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ones", a_ones, 0);
        chk("rst_tens", a_tens, 0);
        chk("rst_hex0", a_hex0, 7'h40);
        chk("rst_hex1", a_hex1, 7'h40);
        chk("rst_seen", a_seen, 0);
        chk("rst_wrap", a_wrap, 0);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("high_at_release_ignored", a_tens * 10 + a_ones, 0);
        chk("high_at_release_no_seen", seen_cnt, 0);
        tick_in = 1'b0;
        model_armed = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) run_row(i);

        // Clear coincides with a detected edge at count 42
        @(posedge clk);
        #1 tick_in = 1'b1;
        e = '{0, 1'b0, 0, 1'b0};
        sb_q.push_back(e);
        model_a = 0;
        model_b = 0;
        s0 = seen_cnt;
        @(posedge clk);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clr_edge_count", a_tens * 10 + a_ones, 0);
        chk("clr_edge_wrap", a_wrap, 0);
        chk("clr_edge_seen", a_seen, 1);
        @(posedge clk);
        #1;
        chk("clr_edge_hex0", a_hex0, 7'h40);
        chk("clr_edge_hex1", a_hex1, 7'h40);
        repeat (2) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (4) @(posedge clk);

        run_row(8);

        // Asynchronous reset at 57, between clock edges
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_ones", a_ones, 0);
        chk("async_tens", a_tens, 0);
        chk("async_hex0", a_hex0, 7'h40);
        chk("async_hex1", a_hex1, 7'h40);
        chk("async_b_count", b_tens * 10 + b_ones, 0);
        chk("async_b_hex0", b_hex0, 7'h40);
        model_a = 0;
        model_b = 0;
        model_armed = 1'b0;
        s0 = seen_cnt;
        @(posedge clk);
        #1 tick_in = 1'b1;
        @(posedge clk);
        #1 tick_in = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_armed = 1'b1;
        repeat (4) @(posedge clk);
        #2 tick_in = 1'b1;
        #4 tick_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_count", a_tens * 10 + a_ones, 0);
        chk("glitch_seen", seen_cnt - s0, 0);

        do_tick();
        repeat (2) @(posedge clk);
        #1;
        chk("after_reset_count", a_tens * 10 + a_ones, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
